act_check_unit: RTL and testbench

Access-check initiator for the access control table. Accepts per-core memory access requests, maps the address to a block index, and performs a CHECK_ACCESS read of the ACT memory through its check port under an arbitration grant. It then evaluates the returned entry's owner and read/write masks and returns a grant/deny response with a fault cause. Sits between the core-side MPU request path and the shared ACT memory, alongside the malloc and dealloc units.

---
 rtl/act_check_unit_pkg.sv | 19 +
 rtl/act_perm_eval.sv | 15 +
 rtl/act_check_unit.sv | 121 ++++++++++++
 tb/tb_act_check_unit.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/act_check_unit_pkg.sv
// act_check_unit_pkg: ACT entry layout, opcodes, fault causes and check-FSM states
// shared by the access-check path.
package act_check_unit_pkg;
    localparam int CORE_BITS        = 2;
    localparam int CORE_COUNT       = 2 ** CORE_BITS;
    localparam int BLOCK_COUNT      = 16;
    localparam int BLOCK_COUNT_BITS = $clog2(BLOCK_COUNT);

    typedef enum logic [1:0] {MALLOC, DEALLOC, CHECK_ACCESS} act_op_t;
    typedef enum logic [1:0] {OK, OUT_OF_RANGE, INVALID, NO_PERM} fault_cause_t;
    typedef enum logic [2:0] {IDLE, REQ, ISSUE, CAPTURE, RESP} check_state_t;

    typedef struct packed {
        logic                  valid;
        logic [CORE_BITS-1:0]  owner;
        logic [CORE_COUNT-1:0] read_mask;
        logic [CORE_COUNT-1:0] write_mask;
    } entry_t;
endpackage

// File: rtl/act_perm_eval.sv
// act_perm_eval: combinational entry/core/write to fault cause evaluator.
module act_perm_eval
    import act_check_unit_pkg::*;
(
    input  entry_t               entry_i,
    input  logic [CORE_BITS-1:0] core_i,
    input  logic                 write_i,
    output fault_cause_t         cause_o
);
    logic mask_hit;
    assign mask_hit = write_i ? entry_i.write_mask[core_i] : entry_i.read_mask[core_i];
    assign cause_o  = !entry_i.valid             ? INVALID :
                      (entry_i.owner == core_i)  ? OK      :
                      mask_hit                   ? OK      : NO_PERM;
endmodule

// File: rtl/act_check_unit.sv
// act_check_unit: maps core access requests to ACT blocks, reads the entry through
// the check port under arbitration and returns a grant/deny response.
module act_check_unit
    import act_check_unit_pkg::*;
#(
    parameter int                    ADDR_WIDTH      = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = 32'h0000_1000,
    parameter int                    BLOCK_SIZE_BITS = 6,
    parameter int                    CORE_ID_BITS    = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [ADDR_WIDTH-1:0]       req_addr,
    input  logic [CORE_ID_BITS-1:0]     req_core,
    input  logic                        req_write,
    output logic                        resp_valid,
    input  logic                        resp_ready,
    output logic                        resp_grant,
    output fault_cause_t                resp_cause,
    output logic                        act_req,
    input  logic                        act_gnt,
    output logic                        act_cs,
    output act_op_t                     act_op,
    output logic [BLOCK_COUNT_BITS-1:0] act_check_addr,
    input  entry_t                      act_check_rdata,
    input  logic                        act_bsy,
    output logic [15:0]                 fault_cnt
);
    check_state_t                state_q, state_d;
    logic [BLOCK_COUNT_BITS-1:0] idx_q, idx_d;
    logic [CORE_ID_BITS-1:0]     core_q, core_d;
    logic                        write_q, write_d;
    logic                        grant_q, grant_d;
    fault_cause_t                cause_q, cause_d;
    logic [15:0]                 fault_cnt_q, fault_cnt_d;
    logic                        bsy_prev_q, bsy_ok_q;
    logic [ADDR_WIDTH-1:0]       offset, shifted;
    logic                        oor;
    fault_cause_t                eval_cause;

    // Range test on the full shifted width so high offsets never alias onto a block.
    assign offset  = req_addr - BASE_ADDR;
    assign shifted = offset >> BLOCK_SIZE_BITS;
    assign oor     = (req_addr < BASE_ADDR) || (shifted >= ADDR_WIDTH'(BLOCK_COUNT));

    act_perm_eval u_eval (
        .entry_i (act_check_rdata),
        .core_i  (core_q),
        .write_i (write_q),
        .cause_o (eval_cause)
    );

    assign req_ready      = state_q == IDLE;
    assign resp_valid     = state_q == RESP;
    assign resp_grant     = grant_q;
    assign resp_cause     = cause_q;
    assign act_req        = (state_q == REQ) || (state_q == ISSUE) || (state_q == CAPTURE);
    assign act_cs         = state_q == ISSUE;
    assign act_op         = CHECK_ACCESS;
    assign act_check_addr = idx_q;
    assign fault_cnt      = fault_cnt_q;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        core_d      = core_q;
        write_d     = write_q;
        grant_d     = grant_q;
        cause_d     = cause_q;
        fault_cnt_d = fault_cnt_q;
        case (state_q)
            IDLE: if (req_valid) begin
                idx_d   = shifted[BLOCK_COUNT_BITS-1:0];
                core_d  = req_core;
                write_d = req_write;
                grant_d = 1'b0;
                cause_d = oor ? OUT_OF_RANGE : OK;
                state_d = oor ? RESP : REQ;
            end
            REQ:     state_d = (act_gnt && bsy_ok_q) ? ISSUE : REQ;
            ISSUE:   state_d = act_bsy ? REQ : CAPTURE;
            CAPTURE: begin
                state_d = act_bsy ? REQ : RESP;
                cause_d = act_bsy ? cause_q : eval_cause;
                grant_d = act_bsy ? grant_q : (eval_cause == OK);
            end
            RESP: if (resp_ready) begin
                state_d     = IDLE;
                fault_cnt_d = (!grant_q && fault_cnt_q != 16'hFFFF) ? fault_cnt_q + 16'd1 : fault_cnt_q;
            end
            default: state_d = IDLE;
        endcase
    end

    // bsy_ok needs two consecutive low samples; the memory ignores cs as bsy falls.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            core_q      <= '0;
            write_q     <= 1'b0;
            grant_q     <= 1'b0;
            cause_q     <= OK;
            fault_cnt_q <= '0;
            bsy_prev_q  <= 1'b1;
            bsy_ok_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            core_q      <= core_d;
            write_q     <= write_d;
            grant_q     <= grant_d;
            cause_q     <= cause_d;
            fault_cnt_q <= fault_cnt_d;
            bsy_prev_q  <= act_bsy;
            bsy_ok_q    <= !act_bsy && !bsy_prev_q;
        end
    end
endmodule

// File: tb/tb_act_check_unit.sv
// tb_act_check_unit: directed bench with an ACT memory model and a response scoreboard.
module tb_act_check_unit;
    import act_check_unit_pkg::*;

    typedef struct packed {
        logic         grant;
        fault_cause_t cause;
    } exp_t;

    logic                        clk, rst;
    logic                        req_valid, req_ready, req_write;
    logic [31:0]                 req_addr;
    logic [1:0]                  req_core;
    logic                        resp_valid, resp_ready, resp_grant;
    fault_cause_t                resp_cause;
    logic                        act_req, act_gnt, act_cs, act_bsy;
    act_op_t                     act_op;
    logic [BLOCK_COUNT_BITS-1:0] act_check_addr;
    entry_t                      rdata;
    logic [15:0]                 fault_cnt;

    entry_t mem [BLOCK_COUNT];
    int     cs_cnt = 0, req_cnt = 0, cs_base, req_base;
    logic [BLOCK_COUNT_BITS-1:0] last_addr;
    int     checks = 0, failures = 0, exp_fc = 0;
    time    t_acc;
    exp_t   q[$];

    act_check_unit dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_core(req_core), .req_write(req_write),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_grant(resp_grant), .resp_cause(resp_cause),
        .act_req(act_req), .act_gnt(act_gnt), .act_cs(act_cs), .act_op(act_op),
        .act_check_addr(act_check_addr), .act_check_rdata(rdata),
        .act_bsy(act_bsy), .fault_cnt(fault_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered-read ACT memory plus activity counters.
    always @(posedge clk) begin
        if (act_cs) begin
            rdata     <= mem[act_check_addr];
            last_addr <= act_check_addr;
            cs_cnt    <= cs_cnt + 1;
        end
        if (act_req) req_cnt <= req_cnt + 1;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] a, input logic [1:0] c, input logic w,
                        input logic g, input fault_cause_t ca);
        exp_t e;
        chk("req_ready_idle", req_ready, 1);
        req_valid = 1'b1; req_addr = a; req_core = c; req_write = w;
        e.grant = g; e.cause = ca;
        q.push_back(e);
        t_acc = $time; cs_base = cs_cnt; req_base = req_cnt;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(input int exp_lat, input int exp_cs, input int exp_req, input int hold);
        exp_t e;
        int   lat;
        while (!resp_valid && ($time - t_acc) < 400) @(negedge clk);
        lat = int'(($time - t_acc) / 10);
        chk("resp_seen", resp_valid, 1);
        if (exp_lat > 0) chk("latency", lat, exp_lat);
        chk("cs_pulses", cs_cnt - cs_base, exp_cs);
        if (exp_req >= 0) chk("req_cycles", req_cnt - req_base, exp_req);
        e = '0;
        if (q.size() == 0) begin
            checks++; failures++;
            $display("FAIL scoreboard observed=empty expected=entry");
        end else e = q.pop_front();
        chk("grant", resp_grant, e.grant);
        chk("cause", resp_cause, e.cause);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", resp_valid, 1);
            chk("hold_grant", resp_grant, e.grant);
            chk("hold_cause", resp_cause, e.cause);
            chk("hold_req_ready", req_ready, 0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        if (!e.grant) exp_fc++;
        chk("resp_done", resp_valid, 0);
        chk("fault_cnt", fault_cnt, exp_fc);
    endtask

    initial begin
        int seen;
        for (int i = 0; i < BLOCK_COUNT; i++) mem[i] = '0;
        rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_core = '0; req_write = 1'b0;
        resp_ready = 1'b1; act_gnt = 1'b1; act_bsy = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_grant", resp_grant, 0);
        chk("rst_cause", resp_cause, OK);
        chk("rst_act_req", act_req, 0);
        chk("rst_act_cs", act_cs, 0);
        chk("rst_addr", act_check_addr, 0);
        chk("rst_fault_cnt", fault_cnt, 0);
        repeat (2) @(negedge clk);

        // owner read of block 3
        mem[3] = '{valid: 1'b1, owner: 2'd2, read_mask: 4'b0, write_mask: 4'b0};
        send(32'h10C0, 2'd2, 1'b0, 1'b1, OK);
        wait_resp(4, 1, 3, 0);
        chk("owner_cs_addr", last_addr, 3);

        // mask deny then allow on block 5
        mem[5] = '{valid: 1'b1, owner: 2'd0, read_mask: 4'b0010, write_mask: 4'b0};
        send(32'h1140, 2'd1, 1'b1, 1'b0, NO_PERM);
        wait_resp(4, 1, 3, 0);
        send(32'h1140, 2'd1, 1'b0, 1'b1, OK);
        wait_resp(4, 1, 3, 0);

        // range boundaries: no ACT traffic, response next cycle
        send(32'h0FFF, 2'd0, 1'b0, 1'b0, OUT_OF_RANGE);
        wait_resp(1, 0, 0, 0);
        send(32'h1400, 2'd0, 1'b0, 1'b0, OUT_OF_RANGE);
        wait_resp(1, 0, 0, 0);
        send(32'h5000, 2'd3, 1'b1, 1'b0, OUT_OF_RANGE);
        wait_resp(1, 0, 0, 0);
        send(32'h13C0, 2'd0, 1'b0, 1'b0, INVALID);
        wait_resp(4, 1, 3, 0);
        chk("last_block_addr", last_addr, 15);

        // table clear: cs held off until bsy low for two samples
        act_bsy = 1'b1;
        for (int i = 0; i < BLOCK_COUNT; i++) mem[i] = '0;
        repeat (3) @(negedge clk);
        act_bsy = 1'b0;
        send(32'h1000, 2'd1, 1'b0, 1'b0, INVALID);
        wait_resp(5, 1, 4, 0);
        chk("clear_cs_addr", last_addr, 0);

        // arbitration contention
        mem[7] = '{valid: 1'b1, owner: 2'd1, read_mask: 4'b0, write_mask: 4'b0};
        act_gnt = 1'b0;
        send(32'h11C0, 2'd1, 1'b0, 1'b1, OK);
        for (int i = 0; i < 5; i++) begin
            chk("cont_act_req", act_req, 1);
            chk("cont_act_cs", act_cs, 0);
            @(negedge clk);
        end
        act_gnt = 1'b1;
        wait_resp(0, 1, -1, 0);

        // response backpressure
        resp_ready = 1'b0;
        send(32'h11C0, 2'd1, 1'b1, 1'b1, OK);
        wait_resp(4, 1, 3, 3);

        // bsy pulse in CAPTURE: stale invalid read must be discarded
        mem[7] = '0;
        send(32'h11C0, 2'd1, 1'b0, 1'b1, OK);
        @(negedge clk);
        @(negedge clk);
        chk("bsy_act_req", act_req, 1);
        act_bsy = 1'b1;
        mem[7] = '{valid: 1'b1, owner: 2'd1, read_mask: 4'b0, write_mask: 4'b0};
        @(negedge clk);
        act_bsy = 1'b0;
        wait_resp(9, 2, 8, 0);

        // reset while in ISSUE
        req_valid = 1'b1; req_addr = 32'h11C0; req_core = 2'd2; req_write = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("issue_cs", act_cs, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_cs", act_cs, 0);
        chk("rst_mid_req", act_req, 0);
        chk("rst_mid_resp", resp_valid, 0);
        chk("rst_mid_fault_cnt", fault_cnt, 0);
        rst = 1'b0;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        chk("rst_no_resp", seen, 0);
        chk("rst_idle_ready", req_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
